// File: rtl/mips_shift_pkg.sv
// Shared encodings and defaults for the multi-cycle MIPS shift unit.
package mips_shift_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_var_shifter_shift_step.sv
// One-bit shift of a data word; the reserved op code falls through to sll.
module shift_step
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = {din[WIDTH-2:0], 1'b0};
        unique case (op)
            OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
            OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            default: dout = {din[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/seq_var_shifter.sv
// Bit-serial sll/srl/sra unit: one position per clock, start/done handshake.
module seq_var_shifter
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             use_var,
    input  logic [SHW-1:0]   shamt_imm,
    input  logic [WIDTH-1:0] shamt_reg,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [SHW-1:0] ONE  = 1;
    localparam logic [SHW-1:0] ZERO = '0;

    state_t           state;
    logic [SHW-1:0]   count;
    logic [1:0]       op_q;
    logic [SHW-1:0]   n;
    logic [WIDTH-1:0] stepped;

    // rs bits above the shift-count field never influence the shift
    logic unused_hi;
    assign unused_hi = ^shamt_reg[WIDTH-1:SHW];

    assign n = use_var ? shamt_reg[SHW-1:0] : shamt_imm;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op   (op_q),
        .din  (result),
        .dout (stepped)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= ZERO;
            op_q   <= OP_SLL;
            result <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q   <= op;
                        result <= data_in;
                        count  <= n;
                        state  <= (n != ZERO) ? S_SHIFT : S_DONE;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    result <= stepped;
                    count  <= count - ONE;
                    if (count == ONE)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_var_shifter.sv
// Directed self-checking bench for seq_var_shifter.
module tb_seq_var_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        use_var;
    logic [4:0]  shamt_imm;
    logic [31:0] shamt_reg;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    seq_var_shifter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .use_var   (use_var),
        .shamt_imm (shamt_imm),
        .shamt_reg (shamt_reg),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive an accept at the next rising edge (E0); returns 1ns after E0.
    task automatic go(input logic [1:0] o, input logic uv,
                      input logic [4:0] imm, input logic [31:0] sreg,
                      input logic [31:0] din);
        op        = o;
        use_var   = uv;
        shamt_imm = imm;
        shamt_reg = sreg;
        data_in   = din;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Count edges until done; every wait is bounded.
    task automatic wait_done(input string tag, input int exp_edges,
                             input logic [31:0] exp_res);
        int edges = 0;
        int bcnt  = 0;
        while (!done && edges < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_done"},  {31'b0, done}, 32'd1);
        chk({tag, "_edges"}, edges,         exp_edges);
        chk({tag, "_busy"},  bcnt,          exp_edges);
        chk({tag, "_res"},   result,        exp_res);
    endtask

    initial begin
        int dseen;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        use_var   = 1'b0;
        shamt_imm = 5'd0;
        shamt_reg = 32'h0;
        data_in   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_res",  result,        32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // reset while shifting aborts with no done strobe
        go(2'b00, 1'b0, 5'd20, 32'h0, 32'h0000_FFFF);
        repeat (6) @(posedge clk);
        #3;
        chk("mid_busy_pre", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_done", {31'b0, done}, 32'd0);
        chk("mid_res",  result,        32'h0);
        @(negedge clk);
        reset = 1'b0;
        dseen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) dseen++;
        end
        chk("mid_nodone", dseen, 0);

        // sll by 4
        go(2'b00, 1'b0, 5'd4, 32'h0, 32'h0000_00F1);
        wait_done("sll4", 4, 32'h0000_0F10);
        @(posedge clk);
        #1;
        chk("sll4_done1cyc", {31'b0, done}, 32'd0);
        chk("sll4_idle",     {31'b0, busy}, 32'd0);
        chk("sll4_hold",     result,        32'h0000_0F10);

        // worst-case count from register
        go(2'b11, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("sra31", 31, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        go(2'b01, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("srl31", 31, 32'h0000_0001);
        @(posedge clk);
        #1;

        // zero counts finish on the accept edge
        go(2'b01, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF);
        wait_done("srl0", 0, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        go(2'b01, 1'b1, 5'd7, 32'h0000_0020, 32'hDEAD_BEEF);
        wait_done("srl0v", 0, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        go(2'b00, 1'b1, 5'd0, 32'hFFFF_FFE0, 32'h0000_0003);
        wait_done("trunc0", 0, 32'h0000_0003);
        @(posedge clk);
        #1;
        go(2'b00, 1'b1, 5'd0, 32'h0000_0025, 32'h0000_0001);
        wait_done("trunc5", 5, 32'h0000_0020);
        @(posedge clk);
        #1;

        // start during SHIFT is ignored
        go(2'b01, 1'b0, 5'd8, 32'h0, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1;
        op        = 2'b00;
        shamt_imm = 5'd1;
        data_in   = 32'h0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        chk("ign_busy", {31'b0, busy}, 32'd1);
        wait_done("ign", 5, 32'h0012_3456);

        // back-to-back accept from DONE
        op        = 2'b00;
        use_var   = 1'b0;
        shamt_imm = 5'd1;
        data_in   = 32'h0000_0001;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_done", {31'b0, done}, 32'd0);
        wait_done("b2b", 1, 32'h0000_0002);
        @(posedge clk);
        #1;

        // reserved op behaves as sll
        go(2'b10, 1'b0, 5'd2, 32'h0, 32'h0000_0003);
        wait_done("rsv", 2, 32'h0000_000C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
